// File: rtl/cx_dma_sched_pkg.sv
// Shared types for the DMA scheduler: tracker entry, scheduler request and FSM states.
package cx_dma_types;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned SCHED_ID_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] base_address;
        logic [ADDR_W-1:0] end_address;
        logic              rw;
    } track_entry_t;

    localparam int unsigned ENTRY_W = $bits(track_entry_t);

    typedef enum logic [2:0] {
        IDLE,
        LKUP,
        LKUP_WAIT,
        BACKOFF,
        ALLOC,
        ALLOC_WAIT,
        ISSUE
    } sched_state_e;

    // Requester id is sized for the largest supported NUM_REQ; users take the low REQ_W bits.
    typedef struct packed {
        track_entry_t            entry;
        logic [SCHED_ID_W-1:0]   id;
    } sched_req_t;

endpackage

// File: rtl/cx_dma_sched_if.sv
// Requester, tracker and DMA-engine signals of the scheduler; master is the scheduler side.
interface cx_dma_sched_if
    import cx_dma_types::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DEPTH   = 8
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned REQ_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ENTRY_W-1:0] req_entry;
    logic [NUM_REQ-1:0]         req_ready;

    logic                       lkup_req_valid;
    logic                       lkup_req_ready;
    logic [REQ_W-1:0]           lkup_req_id;
    logic [ENTRY_W-1:0]         lkup_req_data;
    logic                       lkup_resp_valid;
    logic                       lkup_resp_ready;
    logic                       lkup_resp_data;

    logic                       alloc_req_valid;
    logic                       alloc_req_ready;
    logic [REQ_W-1:0]           alloc_req_id;
    logic [ENTRY_W-1:0]         alloc_req_data;
    logic                       alloc_resp_valid;
    logic                       alloc_resp_ready;
    logic [IDX_W-1:0]           alloc_resp_data;

    logic                       remove_valid;
    logic [IDX_W-1:0]           remove_data;

    logic                       issue_valid;
    logic                       issue_ready;
    logic [ENTRY_W-1:0]         issue_entry;
    logic [IDX_W-1:0]           issue_tag;

    logic                       done_valid;
    logic [IDX_W-1:0]           done_tag;

    logic [IDX_W:0]             inflight;

    modport master (
        input  req_valid, req_entry,
        output req_ready,
        output lkup_req_valid, lkup_req_id, lkup_req_data,
        input  lkup_req_ready,
        input  lkup_resp_valid, lkup_resp_data,
        output lkup_resp_ready,
        output alloc_req_valid, alloc_req_id, alloc_req_data,
        input  alloc_req_ready,
        input  alloc_resp_valid, alloc_resp_data,
        output alloc_resp_ready,
        output remove_valid, remove_data,
        output issue_valid, issue_entry, issue_tag,
        input  issue_ready,
        input  done_valid, done_tag,
        output inflight
    );

    modport slave (
        output req_valid, req_entry,
        input  req_ready,
        input  lkup_req_valid, lkup_req_id, lkup_req_data,
        output lkup_req_ready,
        output lkup_resp_valid, lkup_resp_data,
        input  lkup_resp_ready,
        input  alloc_req_valid, alloc_req_id, alloc_req_data,
        output alloc_req_ready,
        output alloc_resp_valid, alloc_resp_data,
        input  alloc_resp_ready,
        input  remove_valid, remove_data,
        input  issue_valid, issue_entry, issue_tag,
        output issue_ready,
        output done_valid, done_tag,
        input  inflight
    );

endinterface

// File: rtl/cx_dma_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant searching upward from rr_ptr; advance moves rr_ptr past the winner.
module cx_rr_arb #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
    localparam int unsigned REQ_W = $clog2(NUM_REQ);

    logic [REQ_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_W-1:0] idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = REQ_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (advance && found) begin
            rr_ptr_d = REQ_W'((32'(grant_idx) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/cx_dma_sched.sv
// DMA scheduler: arbitrates requesters, checks the tracker for conflicts, allocates a slot, issues to the engine.
module cx_dma_sched
    import cx_dma_types::*;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned BACKOFF_CYCLES = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    cx_dma_sched_if.master bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned REQ_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W  = $clog2(BACKOFF_CYCLES + 1);
    localparam int unsigned INFL_W = IDX_W + 1;

    sched_state_e       state_q, state_d;
    sched_req_t         req_q, req_d;
    logic [IDX_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   backoff_q, backoff_d;
    logic [INFL_W-1:0]  inflight_q, inflight_d;
    logic [DEPTH-1:0]   inflight_map_q, inflight_map_d;
    logic               remove_valid_q, remove_valid_d;
    logic [IDX_W-1:0]   remove_data_q, remove_data_d;

    logic [NUM_REQ-1:0] gnt;
    logic [REQ_W-1:0]   gnt_idx;
    logic               in_idle;
    logic               alloc_hs;
    logic               unused_id_bits;

    assign in_idle  = (state_q == IDLE) && i_rst_n;
    assign alloc_hs = (state_q == ALLOC) && bus.alloc_req_ready;

    cx_rr_arb #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .req      (bus.req_valid),
        .advance  (in_idle),
        .grant    (gnt),
        .grant_idx(gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        tag_d     = tag_q;
        backoff_d = backoff_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_d.entry = track_entry_t'(bus.req_entry[32'(gnt_idx)*ENTRY_W +: ENTRY_W]);
                    req_d.id    = SCHED_ID_W'(gnt_idx);
                    state_d     = LKUP;
                end
            end
            LKUP: begin
                if (bus.lkup_req_ready) state_d = LKUP_WAIT;
            end
            LKUP_WAIT: begin
                if (bus.lkup_resp_valid) begin
                    if (bus.lkup_resp_data) begin
                        state_d   = BACKOFF;
                        backoff_d = CNT_W'(BACKOFF_CYCLES);
                    end else begin
                        state_d = ALLOC;
                    end
                end
            end
            BACKOFF: begin
                // Granted request is retained; the lookup is simply retried after the wait.
                if (backoff_q != '0) backoff_d = backoff_q - CNT_W'(1);
                if (backoff_q <= CNT_W'(1)) state_d = LKUP;
            end
            ALLOC: begin
                if (bus.alloc_req_ready) state_d = ALLOC_WAIT;
            end
            ALLOC_WAIT: begin
                if (bus.alloc_resp_valid) begin
                    tag_d   = bus.alloc_resp_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.issue_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        remove_valid_d = bus.done_valid;
        remove_data_d  = bus.done_tag;

        inflight_d = inflight_q;
        if (alloc_hs && !remove_valid_q && inflight_q != INFL_W'(DEPTH)) begin
            inflight_d = inflight_q + INFL_W'(1);
        end else if (!alloc_hs && remove_valid_q && inflight_q != '0) begin
            inflight_d = inflight_q - INFL_W'(1);
        end

        inflight_map_d = inflight_map_q;
        if (remove_valid_q) inflight_map_d[remove_data_q] = 1'b0;
        if (state_q == ALLOC_WAIT && bus.alloc_resp_valid) inflight_map_d[bus.alloc_resp_data] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            req_q          <= '0;
            tag_q          <= '0;
            backoff_q      <= '0;
            inflight_q     <= '0;
            inflight_map_q <= '0;
            remove_valid_q <= 1'b0;
            remove_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            tag_q          <= tag_d;
            backoff_q      <= backoff_d;
            inflight_q     <= inflight_d;
            inflight_map_q <= inflight_map_d;
            remove_valid_q <= remove_valid_d;
            remove_data_q  <= remove_data_d;
        end
    end

    a_done_tracked: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        bus.done_valid |-> inflight_map_q[bus.done_tag]);

    assign unused_id_bits = ^req_q.id;

    assign bus.req_ready        = gnt & {NUM_REQ{in_idle}};
    assign bus.lkup_req_valid   = (state_q == LKUP) && i_rst_n;
    assign bus.lkup_req_id      = req_q.id[REQ_W-1:0];
    assign bus.lkup_req_data    = req_q.entry;
    assign bus.lkup_resp_ready  = (state_q == LKUP_WAIT) && i_rst_n;
    assign bus.alloc_req_valid  = (state_q == ALLOC) && i_rst_n;
    assign bus.alloc_req_id     = req_q.id[REQ_W-1:0];
    assign bus.alloc_req_data   = req_q.entry;
    assign bus.alloc_resp_ready = (state_q == ALLOC_WAIT) && i_rst_n;
    assign bus.remove_valid     = remove_valid_q && i_rst_n;
    assign bus.remove_data      = remove_data_q;
    assign bus.issue_valid      = (state_q == ISSUE) && i_rst_n;
    assign bus.issue_entry      = req_q.entry;
    assign bus.issue_tag        = tag_q;
    assign bus.inflight         = inflight_q;

endmodule

// File: tb/tb_cx_dma_sched.sv
// Directed bench for cx_dma_sched: the bench plays requesters, tracker and DMA engine.
module tb_cx_dma_sched;
    import cx_dma_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cx_dma_sched_if #(.NUM_REQ(2), .DEPTH(8)) bus ();

    cx_dma_sched #(
        .DEPTH         (8),
        .NUM_REQ       (2),
        .BACKOFF_CYCLES(4)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int n_rr = 0;
    int n_lk = 0;
    int n_al = 0;
    int n_bo = 0;

    track_entry_t e0, e1;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.req_ready != 2'b00) n_rr++;
            if (bus.lkup_req_valid && bus.lkup_req_ready) n_lk++;
            if (bus.alloc_req_valid && bus.alloc_req_ready) n_al++;
            if (dut.state_q == BACKOFF) n_bo++;
        end
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return bus.lkup_req_valid;
            1:       return bus.lkup_resp_ready;
            2:       return bus.alloc_req_valid;
            3:       return bus.alloc_resp_ready;
            4:       return bus.issue_valid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hi(input string tag, input int which);
        int n = 0;
        while (!sel(which) && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 96'(sel(which)), 96'(1));
    endtask

    task automatic grant(input logic [1:0] v, input logic [1:0] exp, input bit hold);
        bus.req_valid = v;
        #1;
        chk("req_ready", 96'(bus.req_ready), 96'(exp));
        tick();
        if (!hold) bus.req_valid = 2'b00;
    endtask

    task automatic lookup(input track_entry_t e, input int g, input int n_conf);
        for (int i = 0; i <= n_conf; i++) begin
            wait_hi("lkup_valid", 0);
            chk("lkup_data", 96'(bus.lkup_req_data), 96'(e));
            chk("lkup_id", 96'(bus.lkup_req_id), 96'(g));
            tick();
            wait_hi("lkup_resp_ready", 1);
            bus.lkup_resp_valid = 1'b1;
            bus.lkup_resp_data  = (i < n_conf);
            tick();
            bus.lkup_resp_valid = 1'b0;
            bus.lkup_resp_data  = 1'b0;
        end
    endtask

    task automatic alloc_resp(input logic [2:0] slot);
        wait_hi("alloc_resp_ready", 3);
        bus.alloc_resp_valid = 1'b1;
        bus.alloc_resp_data  = slot;
        tick();
        bus.alloc_resp_valid = 1'b0;
    endtask

    task automatic alloc(input track_entry_t e, input int g, input logic [2:0] slot);
        wait_hi("alloc_valid", 2);
        chk("alloc_data", 96'(bus.alloc_req_data), 96'(e));
        chk("alloc_id", 96'(bus.alloc_req_id), 96'(g));
        tick();
        alloc_resp(slot);
    endtask

    task automatic issue(input track_entry_t e, input logic [2:0] slot);
        wait_hi("issue_valid", 4);
        chk("issue_tag", 96'(bus.issue_tag), 96'(slot));
        chk("issue_entry", 96'(bus.issue_entry), 96'(e));
        tick();
    endtask

    task automatic send_done(input logic [2:0] tag);
        bus.done_valid = 1'b1;
        bus.done_tag   = tag;
        tick();
        bus.done_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_rr, s_lk, s_al, s_bo;
        e0 = '{base_address: 32'h100,  end_address: 32'h1FF,  rw: 1'b1};
        e1 = '{base_address: 32'h2000, end_address: 32'h20FF, rw: 1'b0};
        bus.req_valid        = 2'b11;
        bus.req_entry        = {e1, e0};
        bus.lkup_req_ready   = 1'b1;
        bus.lkup_resp_valid  = 1'b0;
        bus.lkup_resp_data   = 1'b0;
        bus.alloc_req_ready  = 1'b1;
        bus.alloc_resp_valid = 1'b0;
        bus.alloc_resp_data  = '0;
        bus.issue_ready      = 1'b1;
        bus.done_valid       = 1'b0;
        bus.done_tag         = '0;

        // Reset with requests pending: nothing may be accepted or driven.
        repeat (3) tick();
        chk("rst_req_ready", 96'(bus.req_ready), 96'(0));
        chk("rst_lkup_valid", 96'(bus.lkup_req_valid), 96'(0));
        chk("rst_issue_valid", 96'(bus.issue_valid), 96'(0));
        chk("rst_remove_valid", 96'(bus.remove_valid), 96'(0));
        chk("rst_inflight", 96'(bus.inflight), 96'(0));
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        tick();
        chk("post_rst_inflight", 96'(bus.inflight), 96'(0));

        // Single request, clean lookup, slot 3, then completion.
        grant(2'b01, 2'b01, 1'b0);
        lookup(e0, 0, 0);
        alloc(e0, 0, 3'd3);
        chk("t1_inflight", 96'(bus.inflight), 96'(1));
        issue(e0, 3'd3);
        send_done(3'd3);
        chk("t1_remove_valid", 96'(bus.remove_valid), 96'(1));
        chk("t1_remove_data", 96'(bus.remove_data), 96'(3));
        tick();
        chk("t1_inflight_after", 96'(bus.inflight), 96'(0));
        chk("t1_remove_clear", 96'(bus.remove_valid), 96'(0));

        // Two conflicts then clean: requester 1 wins (pointer moved past 0).
        s_rr = n_rr; s_lk = n_lk; s_al = n_al; s_bo = n_bo;
        grant(2'b10, 2'b10, 1'b0);
        lookup(e1, 1, 2);
        alloc(e1, 1, 3'd5);
        issue(e1, 3'd5);
        chk("t2_backoff_cycles", 96'(n_bo - s_bo), 96'(8));
        chk("t2_lookups", 96'(n_lk - s_lk), 96'(3));
        chk("t2_allocs", 96'(n_al - s_al), 96'(1));
        chk("t2_req_ready_pulses", 96'(n_rr - s_rr), 96'(1));
        send_done(3'd5);
        tick();
        chk("t2_inflight", 96'(bus.inflight), 96'(0));

        // Round-robin with both requesters held: 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            grant(2'b11, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
            lookup((i % 2 == 0) ? e0 : e1, i % 2, 0);
            alloc((i % 2 == 0) ? e0 : e1, i % 2, 3'(i));
            issue((i % 2 == 0) ? e0 : e1, 3'(i));
        end
        bus.req_valid = 2'b00;
        chk("rr_inflight", 96'(bus.inflight), 96'(4));
        send_done(3'd0);
        send_done(3'd1);
        chk("rr_remove_data", 96'(bus.remove_data), 96'(1));
        tick();
        chk("rr_inflight_after", 96'(bus.inflight), 96'(2));

        // Full tracker: ALLOC held 20 cycles; then remove coincides with the alloc handshake.
        bus.alloc_req_ready = 1'b0;
        grant(2'b01, 2'b01, 1'b0);
        lookup(e0, 0, 0);
        bus.req_valid = 2'b11;
        wait_hi("full_alloc_valid", 2);
        for (int i = 0; i < 20; i++) begin
            chk("full_alloc_valid_hold", 96'(bus.alloc_req_valid), 96'(1));
            chk("full_alloc_data_hold", 96'(bus.alloc_req_data), 96'(e0));
            chk("full_no_req_ready", 96'(bus.req_ready), 96'(0));
            tick();
        end
        send_done(3'd2);
        chk("full_remove_valid", 96'(bus.remove_valid), 96'(1));
        bus.alloc_req_ready = 1'b1;
        chk("full_inflight_pre", 96'(bus.inflight), 96'(2));
        tick();
        chk("full_inflight_simul", 96'(bus.inflight), 96'(2));
        bus.req_valid = 2'b00;
        alloc_resp(3'd4);
        issue(e0, 3'd4);

        // Done presented in the alloc-handshake cycle at inflight=2.
        grant(2'b01, 2'b01, 1'b0);
        lookup(e0, 0, 0);
        wait_hi("simul_alloc_valid", 2);
        bus.done_valid = 1'b1;
        bus.done_tag   = 3'd3;
        tick();
        bus.done_valid = 1'b0;
        chk("simul_inflight_mid", 96'(bus.inflight), 96'(3));
        chk("simul_remove_valid", 96'(bus.remove_valid), 96'(1));
        tick();
        chk("simul_inflight_end", 96'(bus.inflight), 96'(2));
        alloc_resp(3'd5);
        issue(e0, 3'd5);

        // Reset while ISSUE is stalled.
        bus.issue_ready = 1'b0;
        grant(2'b10, 2'b10, 1'b0);
        lookup(e1, 1, 0);
        alloc(e1, 1, 3'd6);
        wait_hi("stall_issue_valid", 4);
        repeat (3) tick();
        chk("stall_issue_hold", 96'(bus.issue_valid), 96'(1));
        chk("stall_issue_tag", 96'(bus.issue_tag), 96'(6));
        chk("stall_inflight", 96'(bus.inflight), 96'(3));
        rst_n = 1'b0;
        tick();
        chk("midrst_issue_valid", 96'(bus.issue_valid), 96'(0));
        chk("midrst_inflight", 96'(bus.inflight), 96'(0));
        chk("midrst_state", 96'(dut.state_q), 96'(IDLE));
        rst_n = 1'b1;
        bus.issue_ready = 1'b1;
        tick();
        chk("postrst_issue_valid", 96'(bus.issue_valid), 96'(0));
        chk("postrst_lkup_valid", 96'(bus.lkup_req_valid), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
